reg_file_ctrl: RTL



---
 rtl/reg_file_ctrl_pkg.sv | 27 ++
 rtl/reg_file_ctrl_arb.sv | 33 +++
 rtl/reg_file_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and default widths for the register-file control sequencer.
package reg_file_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF  = 4;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned OP_W        = 4;
    localparam int unsigned CNT_W       = 4;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        LOAD
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

endpackage

// File: rtl/reg_file_ctrl_arb.sv
// Two-requester round-robin arbiter; the pointer moves only on a granted handshake.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt_c
);

    // High when requester 1 holds priority for the next contended cycle.
    logic prio1_q;

    always_comb begin
        gnt_c = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !prio1_q)) begin
                gnt_c = 2'b01;
            end else if (req[1]) begin
                gnt_c = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio1_q <= 1'b0;
        end else if (advance) begin
            prio1_q <= gnt_c[0];
        end
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// Control sequencer for the 16x8 register file: instruction read/execute/writeback
// and host loads sharing one write port through a round-robin arbiter.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned INSTR_W     = INSTR_W_DEF,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [OP_W-1:0]    alu_op,
    output logic [ADDR_W-1:0]  RA1,
    output logic [ADDR_W-1:0]  RA2,
    output logic [ADDR_W-1:0]  WA,
    output logic [DATA_W-1:0]  wd,
    output logic               write_enable,
    output logic               busy
);

    state_e              state_q, state_d;
    instr_t              instr_w;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   ld_data_q, ld_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ra1_d, ra2_d, wa_d;
    logic [OP_W-1:0]     alu_op_d;
    logic                we_d;
    logic [1:0]          gnt_c;
    logic                instr_hs_c, ld_hs_c;

    assign instr_w = instr;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rst_n && (state_q == IDLE)),
        .req     ({ld_valid, instr_valid}),
        .advance (instr_hs_c || ld_hs_c),
        .gnt_c   (gnt_c)
    );

    // A grant is only issued to an active request, so a grant is the handshake.
    assign instr_ready = gnt_c[0];
    assign ld_ready    = gnt_c[1];
    assign instr_hs_c  = gnt_c[0];
    assign ld_hs_c     = gnt_c[1];

    // Write data: ALU pass-through during writeback, latched host data during a load.
    assign wd = (state_q == WB)   ? alu_result :
                (state_q == LOAD) ? ld_data_q  : '0;

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        ld_data_d = ld_data_q;
        cnt_d     = cnt_q;
        ra1_d     = RA1;
        ra2_d     = RA2;
        alu_op_d  = alu_op;
        wa_d      = WA;
        we_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_hs_c) begin
                    ra1_d    = ADDR_W'(instr_w.rs1);
                    ra2_d    = ADDR_W'(instr_w.rs2);
                    alu_op_d = instr_w.op;
                    rd_d     = ADDR_W'(instr_w.rd);
                    state_d  = READ;
                end else if (ld_hs_c) begin
                    ld_data_d = ld_data;
                    wa_d      = ld_addr;
                    we_d      = 1'b1;
                    state_d   = LOAD;
                end
            end
            READ: begin
                if (alu_op == OP_NOP) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_W'(EXEC_CYCLES - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    wa_d    = rd_q;
                    we_d    = 1'b1;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WB:      state_d = IDLE;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_q         <= '0;
            ld_data_q    <= '0;
            cnt_q        <= '0;
            RA1          <= '0;
            RA2          <= '0;
            alu_op       <= '0;
            WA           <= '0;
            write_enable <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            ld_data_q    <= ld_data_d;
            cnt_q        <= cnt_d;
            RA1          <= ra1_d;
            RA2          <= ra2_d;
            alu_op       <= alu_op_d;
            WA           <= wa_d;
            write_enable <= we_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule
